fwd_operand_stage: RTL and testbench

- Parametrised, registered successor to the combinational 3:1 operand-select mux used in the execute-stage forwarding path.
- Selects one of N_SRC WIDTH-bit sources: register-file value, MEM-stage forward or WB-stage forward.
- Registers the selected value into the pipeline register, with stall/flush control, valid tracking and illegal-select detection.
- Sits between hazard/forwarding control and the ALU operand inputs.

---
 rtl/fwd_operand_stage.sv | 98 +++++++++
 tb/tb_fwd_operand_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_operand_stage.sv
// Registered N_SRC:1 operand select for the execute-stage forwarding path.
// Stall/flush control, valid tracking and illegal-select detection with a saturating counter.
module fwd_operand_stage #(
  parameter int WIDTH  = 32,
  parameter int N_SRC  = 3,
  parameter int ONEHOT = 0,
  parameter int CNT_W  = 8,
  localparam int SEL_W = (ONEHOT != 0) ? N_SRC : $clog2(N_SRC)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_SRC*WIDTH-1:0] src_i,
  input  logic [SEL_W-1:0]       sel_i,
  input  logic                   in_valid_i,
  input  logic                   stall_i,
  input  logic                   flush_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   valid_o,
  output logic                   sel_err_o,
  output logic [CNT_W-1:0]       err_cnt_o
);

  logic             w_sel_ok;
  logic [WIDTH-1:0] w_sel_data;

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  generate
    if (ONEHOT != 0) begin : g_onehot
      logic [SEL_W-1:0] w_sel_m1;

      // x & (x-1) clears the lowest set bit: zero result means at most one bit was set.
      assign w_sel_m1 = sel_i - SEL_W'(1);
      assign w_sel_ok = (sel_i != '0) && ((sel_i & w_sel_m1) == '0);

      always_comb begin
        w_sel_data = '0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
          if (sel_i[k]) begin
            w_sel_data = w_sel_data | src_i[k*WIDTH +: WIDTH];
          end
        end
      end
    end else begin : g_binary
      // Out-of-range indices match no source, so they never alias onto the last one.
      always_comb begin
        w_sel_ok   = 1'b0;
        w_sel_data = '0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
          if (sel_i == SEL_W'(k)) begin
            w_sel_ok   = 1'b1;
            w_sel_data = src_i[k*WIDTH +: WIDTH];
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else if (flush_i) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (!stall_i) begin
      if (in_valid_i) begin
        r_valid <= 1'b1;
        if (w_sel_ok) begin
          r_data <= w_sel_data;
          r_err  <= 1'b0;
        end else begin
          // Illegal selects drive zero, never a partial OR of sources.
          r_data <= '0;
          r_err  <= 1'b1;
          if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      end else begin
        r_valid <= 1'b0;
        r_err   <= 1'b0;
      end
    end
  end

  assign data_o    = r_data;
  assign valid_o   = r_valid;
  assign sel_err_o = r_err;
  assign err_cnt_o = r_cnt;

endmodule

// File: tb/tb_fwd_operand_stage.sv
// Scoreboard bench for fwd_operand_stage across four parameter configurations
// sharing one stimulus bus; inactive instances are held in stall.
module tb_fwd_operand_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [319:0] g_src;
  logic [15:0]  g_sel;
  logic         g_valid, g_stall, g_flush;
  int unsigned  which;

  logic [31:0] d0_data; logic d0_valid, d0_err; logic [7:0] d0_cnt;
  logic [31:0] d1_data; logic d1_valid, d1_err; logic [1:0] d1_cnt;
  logic [31:0] d2_data; logic d2_valid, d2_err; logic [7:0] d2_cnt;
  logic [63:0] d3_data; logic d3_valid, d3_err; logic [7:0] d3_cnt;

  fwd_operand_stage u_d0 (
    .clk(clk), .rst_n(rst_n), .src_i(g_src[95:0]), .sel_i(g_sel[1:0]),
    .in_valid_i(g_valid), .stall_i(g_stall || which != 0), .flush_i(g_flush && which == 0),
    .data_o(d0_data), .valid_o(d0_valid), .sel_err_o(d0_err), .err_cnt_o(d0_cnt));

  fwd_operand_stage #(.CNT_W(2)) u_d1 (
    .clk(clk), .rst_n(rst_n), .src_i(g_src[95:0]), .sel_i(g_sel[1:0]),
    .in_valid_i(g_valid), .stall_i(g_stall || which != 1), .flush_i(g_flush && which == 1),
    .data_o(d1_data), .valid_o(d1_valid), .sel_err_o(d1_err), .err_cnt_o(d1_cnt));

  fwd_operand_stage #(.ONEHOT(1), .N_SRC(4)) u_d2 (
    .clk(clk), .rst_n(rst_n), .src_i(g_src[127:0]), .sel_i(g_sel[3:0]),
    .in_valid_i(g_valid), .stall_i(g_stall || which != 2), .flush_i(g_flush && which == 2),
    .data_o(d2_data), .valid_o(d2_valid), .sel_err_o(d2_err), .err_cnt_o(d2_cnt));

  fwd_operand_stage #(.WIDTH(64), .N_SRC(5)) u_d3 (
    .clk(clk), .rst_n(rst_n), .src_i(g_src[319:0]), .sel_i(g_sel[2:0]),
    .in_valid_i(g_valid), .stall_i(g_stall || which != 3), .flush_i(g_flush && which == 3),
    .data_o(d3_data), .valid_o(d3_valid), .sel_err_o(d3_err), .err_cnt_o(d3_cnt));

  int cfg_w  [4] = '{32, 32, 32, 64};
  int cfg_n  [4] = '{3, 3, 4, 5};
  int cfg_oh [4] = '{0, 0, 1, 0};
  int cfg_cw [4] = '{8, 2, 8, 8};
  int cfg_sw [4] = '{2, 2, 4, 3};

  typedef struct {
    logic [63:0] data;
    logic        valid;
    logic        err;
    int          cnt;
  } st_t;

  st_t mst [4];
  st_t sb_q [$];
  int  n_checks = 0;
  int  n_errors = 0;

  logic [63:0] obs_data;
  logic        obs_valid, obs_err;
  logic [7:0]  obs_cnt;

  always_comb begin
    obs_data = '0; obs_valid = 1'b0; obs_err = 1'b0; obs_cnt = '0;
    case (which)
      0: begin obs_data = {32'h0, d0_data}; obs_valid = d0_valid; obs_err = d0_err; obs_cnt = d0_cnt; end
      1: begin obs_data = {32'h0, d1_data}; obs_valid = d1_valid; obs_err = d1_err; obs_cnt = {6'h0, d1_cnt}; end
      2: begin obs_data = {32'h0, d2_data}; obs_valid = d2_valid; obs_err = d2_err; obs_cnt = d2_cnt; end
      default: begin obs_data = d3_data; obs_valid = d3_valid; obs_err = d3_err; obs_cnt = d3_cnt; end
    endcase
  end

  function automatic st_t model_next(st_t s, int d, logic [319:0] src, logic [15:0] sel,
                                     logic v, logic st, logic fl);
    st_t          n;
    logic [15:0]  s_sel;
    logic [63:0]  mask;
    logic [319:0] sh;
    bit           ok;
    int           k;
    n     = s;
    s_sel = sel & 16'((1 << cfg_sw[d]) - 1);
    mask  = (cfg_w[d] == 64) ? '1 : ((64'h1 << cfg_w[d]) - 64'h1);
    ok    = 1'b0;
    k     = 0;
    if (fl) begin
      n.valid = 1'b0; n.data = '0; n.err = 1'b0;
    end else if (!st) begin
      if (v) begin
        if (cfg_oh[d] != 0) begin
          if ($countones(s_sel) == 1) begin
            ok = 1'b1;
            for (int i = 0; i < 16; i++) if (s_sel[i]) k = i;
          end
        end else if (int'(s_sel) < cfg_n[d]) begin
          ok = 1'b1;
          k  = int'(s_sel);
        end
        n.valid = 1'b1;
        if (ok) begin
          sh     = src >> (k * cfg_w[d]);
          n.data = sh[63:0] & mask;
          n.err  = 1'b0;
        end else begin
          n.data = '0;
          n.err  = 1'b1;
          if (n.cnt < (1 << cfg_cw[d]) - 1) n.cnt = n.cnt + 1;
        end
      end else begin
        n.valid = 1'b0; n.err = 1'b0;
      end
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d got=%0h exp=%0h", tag, which, got, exp);
    end
  endtask

  task automatic compare_out(input string tag, input st_t e);
    chk({tag, ".data"},  obs_data, e.data);
    chk({tag, ".valid"}, {63'h0, obs_valid}, {63'h0, e.valid});
    chk({tag, ".err"},   {63'h0, obs_err}, {63'h0, e.err});
    chk({tag, ".cnt"},   {56'h0, obs_cnt}, 64'(e.cnt));
  endtask

  task automatic step(input string tag, input logic v, input logic st, input logic fl);
    st_t e;
    g_valid = v; g_stall = st; g_flush = fl;
    e = model_next(mst[which], int'(which), g_src, g_sel, v, st, fl);
    mst[which] = e;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    compare_out(tag, e);
  endtask

  task automatic do_reset(input string tag);
    st_t z;
    z = '{data: '0, valid: 1'b0, err: 1'b0, cnt: 0};
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) mst[d] = z;
    compare_out({tag, ".async"}, z);
    @(posedge clk);
    #1;
    compare_out({tag, ".held"}, z);
    #3 rst_n = 1'b1;
    g_stall = 1'b0; g_flush = 1'b0;
  endtask

  initial begin
    st_t z;
    z = '{data: '0, valid: 1'b0, err: 1'b0, cnt: 0};
    rst_n = 1'b0; g_src = '0; g_sel = '0;
    g_valid = 1'b0; g_stall = 1'b0; g_flush = 1'b0; which = 0;
    for (int d = 0; d < 4; d++) mst[d] = z;
    #8;
    for (int d = 0; d < 4; d++) begin
      which = d;
      #1 compare_out("por", z);
    end
    which = 0;
    rst_n = 1'b1;

    // default configuration: reset mid-stall, latency, stall/flush priority
    g_src[95:0] = {32'hC, 32'hB, 32'hA};
    g_sel = 16'd0; step("d0.loadA", 1, 0, 0);
    g_stall = 1'b1;
    do_reset("d0.rst_stall");
    g_sel = 16'd1; step("d0.postrst", 1, 0, 0);
    g_sel = 16'd0; step("d0.loadA2", 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      g_src[95:0] = {$urandom, $urandom, $urandom};
      step("d0.stall", 1, 1, 0);
    end
    step("d0.stall_flush", 1, 1, 1);
    g_src[95:0] = {32'hC, 32'hB, 32'hA};
    g_sel = 16'd2; step("d0.loadC", 1, 0, 0);
    step("d0.novalid_hold", 0, 0, 0);
    g_sel = 16'd3; step("d0.illegal", 1, 0, 0);
    step("d0.illegal_novalid", 0, 0, 0);
    step("d0.illegal_flush", 1, 0, 1);
    step("d0.illegal2", 1, 0, 0);
    step("d0.illegal_stall", 1, 1, 0);
    g_flush = 1'b1;
    do_reset("d0.rst_flush");
    g_sel = 16'd2; step("d0.postrst2", 1, 0, 0);

    // 2-bit counter saturation
    which = 1;
    g_sel = 16'd3;
    for (int i = 0; i < 6; i++) step("d1.sat", 1, 0, 0);
    g_sel = 16'd0; step("d1.legal_after_sat", 1, 0, 0);

    // one-hot, four sources
    which = 2;
    g_src[127:0] = {32'h13, 32'h12, 32'h11, 32'h10};
    g_sel = 16'b0100; step("d2.hot2", 1, 0, 0);
    g_sel = 16'b0110; step("d2.multihot", 1, 0, 0);
    g_sel = 16'b0000; step("d2.zerohot", 1, 0, 0);
    g_sel = 16'b1000; step("d2.hot3", 1, 0, 0);
    g_sel = 16'b0001; step("d2.hot0", 1, 0, 0);

    // wide configuration, random legal traffic
    which = 3;
    for (int i = 0; i < 1000; i++) begin
      for (int k = 0; k < 5; k++) g_src[k*64 +: 64] = {$urandom, $urandom};
      g_sel = 16'($urandom_range(0, 4));
      step("d3.rand", $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
